qa_drv_hc_fiu_emul: RTL

FIU-side responder for the host-channel driver: it accepts CCI read requests on channel 0 and write requests on channel 1. It backs them with a local on-chip line memory and returns read-data and write-ack responses. It drives the per-channel almost-full flow control. It is the far end of the interface the driver root drives, so the full host-channel stack (FIFOs, arbiters, status manager) can run loopback on the FPGA without a host.

---
 rtl/qa_drv_hc_fiu_emul.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/qa_drv_hc_fiu_emul.sv
// rtl/qa_drv_hc_fiu_emul.sv - FIU-side CCI responder: request FIFOs, line memory, read data / write ack.
// Optional QA_DRV_HC_FIU_EMUL_STALL_EN: LFSR-driven random dequeue stalls.
module qa_drv_hc_fiu_emul #(
    parameter int ADDR_WIDTH     = 10,
    parameter int REQ_FIFO_DEPTH = 16,
    parameter int ALMFULL_SLACK  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  c0tx_valid,
    input  logic [ADDR_WIDTH-1:0] c0tx_addr,
    input  logic [15:0]           c0tx_mdata,
    input  logic                  c1tx_valid,
    input  logic [ADDR_WIDTH-1:0] c1tx_addr,
    input  logic [511:0]          c1tx_data,
    input  logic [15:0]           c1tx_mdata,
    output logic                  c0tx_almfull,
    output logic                  c1tx_almfull,
    output logic                  rd_valid,
    output logic [511:0]          rd_data,
    output logic [15:0]           rd_mdata,
    output logic                  wr_valid,
    output logic [15:0]           wr_mdata,
    output logic [1:0]            overflow
);
    localparam int PW  = $clog2(REQ_FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int RQW = ADDR_WIDTH + 16;
    localparam int WQW = ADDR_WIDTH + 512 + 16;
    localparam logic [CW-1:0] DEPTH_C = CW'(REQ_FIFO_DEPTH);
    localparam logic [CW-1:0] SLACK_C = CW'(ALMFULL_SLACK);

    logic rd_stall, wr_stall;
`ifdef QA_DRV_HC_FIU_EMUL_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
    assign rd_stall = lfsr_q[0];
    assign wr_stall = lfsr_q[1];
`else
    assign rd_stall = 1'b0;
    assign wr_stall = 1'b0;
`endif

    logic [RQW-1:0] rq_mem [REQ_FIFO_DEPTH];
    logic [WQW-1:0] wq_mem [REQ_FIFO_DEPTH];
    logic [511:0]   line_mem [2**ADDR_WIDTH];
    logic [511:0]   rs2_data_q;

    logic [PW-1:0]         rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
    logic [PW-1:0]         wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
    logic [CW-1:0]         rq_cnt_q, rq_cnt_d, wq_cnt_q, wq_cnt_d;
    logic                  rs1_valid_q, rs1_valid_d, rs2_valid_q, rs2_valid_d;
    logic [ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
    logic [15:0]           rs1_mdata_q, rs1_mdata_d, rs2_mdata_q, rs2_mdata_d;
    logic                  ws1_valid_q, ws1_valid_d;
    logic [ADDR_WIDTH-1:0] ws1_addr_q, ws1_addr_d;
    logic [511:0]          ws1_data_q, ws1_data_d;
    logic [15:0]           ws1_mdata_q, ws1_mdata_d;
    logic                  rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
    logic [511:0]          rd_data_q, rd_data_d;
    logic [15:0]           rd_mdata_q, rd_mdata_d, wr_mdata_q, wr_mdata_d;
    logic                  c0_almfull_q, c0_almfull_d, c1_almfull_q, c1_almfull_d;
    logic [1:0]            overflow_q, overflow_d;

    logic rq_full, rq_push, rq_pop, wq_full, wq_push, wq_pop;

    always_comb begin
        rq_full = (rq_cnt_q == DEPTH_C);
        wq_full = (wq_cnt_q == DEPTH_C);
        rq_push = c0tx_valid && !rq_full;
        wq_push = c1tx_valid && !wq_full;
        rq_pop  = (rq_cnt_q != '0) && !rd_stall;
        wq_pop  = (wq_cnt_q != '0) && !wr_stall;

        rq_wptr_d = rq_wptr_q + PW'(rq_push);
        rq_rptr_d = rq_rptr_q + PW'(rq_pop);
        rq_cnt_d  = rq_cnt_q + CW'(rq_push) - CW'(rq_pop);
        wq_wptr_d = wq_wptr_q + PW'(wq_push);
        wq_rptr_d = wq_rptr_q + PW'(wq_pop);
        wq_cnt_d  = wq_cnt_q + CW'(wq_push) - CW'(wq_pop);

        rs1_valid_d = rq_pop;
        {rs1_addr_d, rs1_mdata_d} = rq_pop ? rq_mem[rq_rptr_q] : {rs1_addr_q, rs1_mdata_q};
        rs2_valid_d = rs1_valid_q;
        rs2_mdata_d = rs1_mdata_q;
        rd_valid_d  = rs2_valid_q;
        rd_data_d   = rs2_valid_q ? rs2_data_q  : rd_data_q;
        rd_mdata_d  = rs2_valid_q ? rs2_mdata_q : rd_mdata_q;

        ws1_valid_d = wq_pop;
        {ws1_addr_d, ws1_data_d, ws1_mdata_d} = wq_pop ? wq_mem[wq_rptr_q]
                                                       : {ws1_addr_q, ws1_data_q, ws1_mdata_q};
        wr_valid_d = ws1_valid_q;
        wr_mdata_d = ws1_valid_q ? ws1_mdata_q : wr_mdata_q;

        // Flags follow the occupancy already committed, so they lag an enqueue by one edge.
        c0_almfull_d = (DEPTH_C - rq_cnt_q) <= SLACK_C;
        c1_almfull_d = (DEPTH_C - wq_cnt_q) <= SLACK_C;
        overflow_d   = overflow_q | {c1tx_valid & wq_full, c0tx_valid & rq_full};
    end

    // Storage is never reset; the line memory read register sees the pre-write value on a collision.
    always_ff @(posedge clk) begin
        if (rq_push) rq_mem[rq_wptr_q] <= {c0tx_addr, c0tx_mdata};
        if (wq_push) wq_mem[wq_wptr_q] <= {c1tx_addr, c1tx_data, c1tx_mdata};
        if (ws1_valid_q) line_mem[ws1_addr_q] <= ws1_data_q;
        rs2_data_q <= line_mem[rs1_addr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rq_wptr_q    <= '0;
            rq_rptr_q    <= '0;
            rq_cnt_q     <= '0;
            wq_wptr_q    <= '0;
            wq_rptr_q    <= '0;
            wq_cnt_q     <= '0;
            rs1_valid_q  <= 1'b0;
            rs1_addr_q   <= '0;
            rs1_mdata_q  <= '0;
            rs2_valid_q  <= 1'b0;
            rs2_mdata_q  <= '0;
            ws1_valid_q  <= 1'b0;
            ws1_addr_q   <= '0;
            ws1_data_q   <= '0;
            ws1_mdata_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_mdata_q   <= '0;
            wr_valid_q   <= 1'b0;
            wr_mdata_q   <= '0;
            c0_almfull_q <= 1'b0;
            c1_almfull_q <= 1'b0;
            overflow_q   <= '0;
        end else begin
            rq_wptr_q    <= rq_wptr_d;
            rq_rptr_q    <= rq_rptr_d;
            rq_cnt_q     <= rq_cnt_d;
            wq_wptr_q    <= wq_wptr_d;
            wq_rptr_q    <= wq_rptr_d;
            wq_cnt_q     <= wq_cnt_d;
            rs1_valid_q  <= rs1_valid_d;
            rs1_addr_q   <= rs1_addr_d;
            rs1_mdata_q  <= rs1_mdata_d;
            rs2_valid_q  <= rs2_valid_d;
            rs2_mdata_q  <= rs2_mdata_d;
            ws1_valid_q  <= ws1_valid_d;
            ws1_addr_q   <= ws1_addr_d;
            ws1_data_q   <= ws1_data_d;
            ws1_mdata_q  <= ws1_mdata_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_mdata_q   <= rd_mdata_d;
            wr_valid_q   <= wr_valid_d;
            wr_mdata_q   <= wr_mdata_d;
            c0_almfull_q <= c0_almfull_d;
            c1_almfull_q <= c1_almfull_d;
            overflow_q   <= overflow_d;
        end
    end

    assign c0tx_almfull = c0_almfull_q;
    assign c1tx_almfull = c1_almfull_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_mdata     = rd_mdata_q;
    assign wr_valid     = wr_valid_q;
    assign wr_mdata     = wr_mdata_q;
    assign overflow     = overflow_q;
endmodule
